// File: rtl/trigger_capture_buffer_pkg.sv
// Shared types and constants for the trigger capture buffer.
package trigger_capture_buffer_pkg;

   typedef enum logic [1:0] {FILL, ARMED, CAPTURE, DRAIN} capture_state_t;

   localparam int DROP_CNT_WIDTH = 16;
   localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = '1;

   function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] value);
      return (value == DROP_CNT_MAX) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/trigger_capture_buffer_if.sv
// Frame output stream. A beat transfers on a clock edge where axiov & axior; once axiov is high,
// axiov/axiod/axiol hold unchanged until that transfer, and axiol marks the final beat of a frame.
interface trigger_capture_buffer_if #(
   parameter int SAMPLE_DATA_WIDTH = 8
) ();

   logic                                axiov;
   logic signed [SAMPLE_DATA_WIDTH-1:0] axiod;
   logic                                axiol;
   logic                                axior;

   modport master (output axiov, output axiod, output axiol, input axior);
   modport slave  (input axiov, input axiod, input axiol, output axior);

endinterface

// File: rtl/trigger_capture_buffer_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port with 1-cycle latency.
module trigger_capture_buffer_ram #(
   parameter int DEPTH = 512,
   parameter int WIDTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/trigger_capture_buffer.sv
// Rolling sample history that freezes one pre/post-trigger frame on a trigger rise and drains it
// oldest-first on a valid/ready stream before re-arming.
module trigger_capture_buffer
   import trigger_capture_buffer_pkg::*;
#(
   parameter int SAMPLE_DATA_WIDTH = 8,
   parameter int DEPTH             = 512,
   parameter int PRE_TRIGGER       = 64
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                axiiv,
   input  logic signed [SAMPLE_DATA_WIDTH-1:0] axiid,
   input  logic                                triggered,
   trigger_capture_buffer_if.master            stream,
   output logic                                armed,
   output logic [DROP_CNT_WIDTH-1:0]           dropped,
   output capture_state_t                      state
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PRE_C   = (AW+1)'(PRE_TRIGGER);
   localparam logic [AW:0] POST_C  = (AW+1)'(DEPTH - PRE_TRIGGER);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   fill_cnt;
   logic [AW:0]   post_cnt;
   logic [AW:0]   issue_cnt;
   logic          triggered_q;

   logic                         out_v, out_l;
   logic [SAMPLE_DATA_WIDTH-1:0] out_d;
   logic                         skid_v, skid_l;
   logic [SAMPLE_DATA_WIDTH-1:0] skid_d;
   logic                         pend, pend_l;
   logic [SAMPLE_DATA_WIDTH-1:0] rdata;

   logic       trig_rise;
   logic       store;
   logic       xfer;
   logic [1:0] occ_after;
   logic       issue;

   assign trig_rise = triggered & ~triggered_q;
   assign store     = axiiv && (state != DRAIN);
   assign xfer      = out_v && stream.axior;
   assign armed     = (state == ARMED);

   // Words that will still be held after this edge; a read issued now lands next cycle and
   // must find a free slot in either the output or the skid register.
   assign occ_after = 2'(out_v) + 2'(skid_v) + 2'(pend) - 2'(xfer);
   assign issue     = (state == DRAIN) && (issue_cnt != DEPTH_C) && (occ_after < 2'd2);

   assign stream.axiov = out_v;
   assign stream.axiod = out_d;
   assign stream.axiol = out_l;

   trigger_capture_buffer_ram #(
      .DEPTH (DEPTH),
      .WIDTH (SAMPLE_DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (store),
      .waddr (wr_ptr),
      .wdata (axiid),
      .re    (issue),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= FILL;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill_cnt    <= '0;
         post_cnt    <= '0;
         issue_cnt   <= '0;
         // A level already high when reset is released must not look like a fresh rise.
         triggered_q <= triggered;
         dropped     <= '0;
         out_v       <= 1'b0;
         out_d       <= '0;
         out_l       <= 1'b0;
         skid_v      <= 1'b0;
         skid_d      <= '0;
         skid_l      <= 1'b0;
         pend        <= 1'b0;
         pend_l      <= 1'b0;
      end else begin
         triggered_q <= triggered;
         if (trig_rise && state != ARMED) dropped <= sat_inc(dropped);
         if (store) wr_ptr <= wr_ptr + 1'b1;

         case (state)
            FILL: begin
               if (axiiv) begin
                  fill_cnt <= fill_cnt + 1'b1;
                  if (fill_cnt + 1'b1 == PRE_C) state <= ARMED;
               end
            end
            ARMED: begin
               if (trig_rise) begin
                  if (axiiv && POST_C == 1) begin
                     rd_ptr    <= wr_ptr + 1'b1;
                     issue_cnt <= '0;
                     state     <= DRAIN;
                  end else begin
                     post_cnt <= {{AW{1'b0}}, axiiv};
                     state    <= CAPTURE;
                  end
               end
            end
            CAPTURE: begin
               if (axiiv) begin
                  post_cnt <= post_cnt + 1'b1;
                  if (post_cnt + 1'b1 == POST_C) begin
                     // The slot after the newest sample holds the oldest one of the frame.
                     rd_ptr    <= wr_ptr + 1'b1;
                     issue_cnt <= '0;
                     state     <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (issue) begin
                  rd_ptr    <= rd_ptr + 1'b1;
                  issue_cnt <= issue_cnt + 1'b1;
               end
               if (xfer && out_l) begin
                  fill_cnt <= '0;
                  state    <= FILL;
               end
            end
            default: state <= FILL;
         endcase

         pend   <= issue;
         pend_l <= issue && (issue_cnt == DEPTH_C - 1'b1);

         // Output register refills from the skid first so ordering is preserved.
         if (!out_v || xfer) begin
            if (skid_v) begin
               out_v  <= 1'b1;
               out_d  <= skid_d;
               out_l  <= skid_l;
               skid_v <= pend;
               skid_d <= rdata;
               skid_l <= pend_l;
            end else if (pend) begin
               out_v <= 1'b1;
               out_d <= rdata;
               out_l <= pend_l;
            end else begin
               out_v <= 1'b0;
               out_l <= 1'b0;
            end
         end else if (pend) begin
            skid_v <= 1'b1;
            skid_d <= rdata;
            skid_l <= pend_l;
         end
      end
   end

endmodule
